// File: rtl/stb_pkg.sv
// Shared types and constants for the store buffer slice.
// No logic; elaboration-time helpers only.
// Entries are sized to the default address/data widths; narrower AW/DW values are zero-extended into them.
package stb_pkg;

  localparam int STB_DEPTH = 4;
  localparam int STB_AW    = 32;
  localparam int STB_DW    = 32;

  typedef struct packed {
    logic [STB_AW-1:0] addr;
    logic [STB_DW-1:0] data;
  } stb_entry_t;

  // Pointer width for a ring of 'depth' slots (never narrower than one bit).
  function automatic int stb_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core-side and data_mem-side signals of the store buffer.
// Latency: none, wires only. Backpressure: stall from buffer to core.
// Modports: slave = store buffer view; master = core + data_mem environment view.
interface store_buffer_if
  import stb_pkg::*;
#(
  parameter int AW = STB_AW,
  parameter int DW = STB_DW
);
  // core side
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_MemRead;
  logic          core_MemWrite;
  logic [DW-1:0] core_rdata;
  logic          stall;
  // data_mem side
  logic [AW-1:0] data_address;
  logic [DW-1:0] write_data;
  logic          MemRead;
  logic          MemWrite;
  logic [DW-1:0] read_data;

  modport slave (
    input  core_addr, core_wdata, core_MemRead, core_MemWrite, read_data,
    output core_rdata, stall, data_address, write_data, MemRead, MemWrite
  );

  modport master (
    output core_addr, core_wdata, core_MemRead, core_MemWrite, read_data,
    input  core_rdata, stall, data_address, write_data, MemRead, MemWrite
  );
endinterface

// File: rtl/stb_match.sv
// Youngest-match finder over the occupied ring entries.
// Latency: combinational. Backpressure: none.
// Ports: entries/head/count describe the ring; addr is the lookup key; hit/index give the youngest match.
module stb_match
  import stb_pkg::*;
#(
  parameter int DEPTH = STB_DEPTH,
  parameter int PW    = stb_ptr_w(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  stb_entry_t        entries [DEPTH],
  input  logic [PW-1:0]     head,
  input  logic [CW-1:0]     count,
  input  logic [STB_AW-1:0] addr,
  output logic              hit,
  output logic [PW-1:0]     index
);

  logic [PW-1:0] slot;

  // Walk from oldest to youngest; a later match overrides an earlier one,
  // so the survivor is the youngest entry holding this address.
  always_comb begin
    hit   = 1'b0;
    index = head;
    slot  = head;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      if ((CW'(i) < count) && (entries[slot].addr == addr)) begin
        hit   = 1'b1;
        index = slot;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core's memory stage and data_mem; loads forward from buffered stores.
// Latency: loads 0 cycles; a store accepted at edge N can drain in cycle N+1, each load cycle delays it by one.
// Backpressure: stall when a store meets a full buffer; the core holds the request until accepted.
// Ports: clk/rst (sync, active high), bus (store_buffer_if.slave), count/empty occupancy status.
// Option: define STB_COALESCE_EN to merge a store into the youngest buffered entry with the same address.
module store_buffer
  import stb_pkg::*;
#(
  parameter int  DEPTH = STB_DEPTH,
  parameter int  AW    = STB_AW,
  parameter int  DW    = STB_DW,
  localparam int PW    = stb_ptr_w(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  store_buffer_if.slave bus,
  output logic [CW-1:0] count,
  output logic          empty
);

  stb_entry_t        entries [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [STB_AW-1:0] lookup_addr;
  logic              hit;
  logic [PW-1:0]     hit_idx;
  logic              is_load;
  logic              is_store;
  logic              full;
  logic              drain;
  logic              coalesce;
  logic              enqueue;

  // Loads and stores both present their address on core_addr, so one finder
  // serves forwarding and coalescing.
  assign lookup_addr = STB_AW'(bus.core_addr);

  stb_match #(
    .DEPTH (DEPTH),
    .PW    (PW),
    .CW    (CW)
  ) u_match (
    .entries (entries),
    .head    (head),
    .count   (count),
    .addr    (lookup_addr),
    .hit     (hit),
    .index   (hit_idx)
  );

  // A store issued together with a load is dropped: it neither enqueues nor stalls.
  assign is_load  = bus.core_MemRead;
  assign is_store = bus.core_MemWrite && !bus.core_MemRead;
  assign full     = (count == CW'(DEPTH));
  assign drain    = !rst && !is_load && (count != '0);

`ifdef STB_COALESCE_EN
  // The head entry leaves this cycle when draining, so merging into it would
  // lose the new data; such a store takes a fresh slot instead.
  assign coalesce = !rst && is_store && hit && !(drain && (hit_idx == head));
`else
  assign coalesce = 1'b0;
`endif

  assign enqueue   = !rst && is_store && !full && !coalesce;
  assign bus.stall = !rst && is_store && full && !coalesce;
  assign empty     = (count == '0);

  // Memory port: load has priority, otherwise drain the head entry.
  always_comb begin
    bus.MemRead      = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.data_address = '0;
    bus.write_data   = '0;
    bus.core_rdata   = '0;
    if (!rst) begin
      if (is_load) begin
        bus.MemRead      = 1'b1;
        bus.data_address = bus.core_addr;
        bus.core_rdata   = hit ? entries[hit_idx].data[DW-1:0] : bus.read_data;
      end else if (drain) begin
        bus.MemWrite     = 1'b1;
        bus.data_address = entries[head].addr[AW-1:0];
        bus.write_data   = entries[head].data[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enqueue) tail <= tail + PW'(1);
      if (drain)   head <= head + PW'(1);
      count <= count + CW'(enqueue) - CW'(drain);
    end
  end

  // Entry storage needs no reset: count gates every use of it.
  always_ff @(posedge clk) begin
    if (enqueue) begin
      entries[tail] <= '{addr: lookup_addr, data: STB_DW'(bus.core_wdata)};
    end
    if (coalesce) begin
      entries[hit_idx].data <= STB_DW'(bus.core_wdata);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed sequences followed by random core traffic.
// A queue-based model predicts every cycle's outputs; a negedge monitor compares.
module tb_store_buffer;
  import stb_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  typedef struct packed {
    logic          in_rst;
    logic          rd;
    logic          wr;
    logic          stall;
    logic          empty;
    logic [CW-1:0] count;
  } exp_cyc_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] count;
  logic          empty;

  store_buffer_if #(.AW(32), .DW(32)) bus ();

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count),
    .empty (empty)
  );

  always #5 clk = ~clk;

  // data_mem: 64 words indexed by addr[7:2]; unwritten words read a fixed pattern.
  logic [31:0] dmem [64];
  bit   [63:0] dval;
  always @(posedge clk) begin
    if (bus.MemWrite) begin
      dmem[bus.data_address[7:2]] <= bus.write_data;
      dval[bus.data_address[7:2]] <= 1'b1;
    end
  end
  assign bus.read_data = dval[bus.data_address[7:2]] ? dmem[bus.data_address[7:2]]
                                                     : (32'hD000_0000 | 32'(bus.data_address[7:2]));

  // Reference model state
  ent_t        mq[$];
  logic [31:0] mdl_mem [64];
  bit   [63:0] mdl_val;
  exp_cyc_t    cyc_q[$];
  ent_t        wr_q[$];
  ent_t        ld_q[$];
  logic        last_stall = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [31:0] mdl_rd(input logic [31:0] addr);
    return mdl_val[addr[7:2]] ? mdl_mem[addr[7:2]] : (32'hD000_0000 | 32'(addr[7:2]));
  endfunction

  function automatic int youngest(input logic [31:0] addr);
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a == addr) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle and record what the model says the DUT must show in it.
  task automatic cyc(input logic r, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wd);
    exp_cyc_t e;
    int       j;
    logic     dr;
    logic     co;
    ent_t     t;
    @(posedge clk);
    #1;
    rst               = r;
    bus.core_MemRead  = rd;
    bus.core_MemWrite = wr;
    bus.core_addr     = addr;
    bus.core_wdata    = wd;
    e        = '0;
    e.in_rst = r;
    e.count  = CW'(mq.size());
    e.empty  = (mq.size() == 0);
    if (r) begin
      mq.delete();
    end else if (rd) begin
      e.rd = 1'b1;
      j = youngest(addr);
      t.a = addr;
      t.d = (j >= 0) ? mq[j].d : mdl_rd(addr);
      ld_q.push_back(t);
    end else begin
      dr = (mq.size() > 0);
      if (dr) begin
        e.wr = 1'b1;
        wr_q.push_back(mq[0]);
      end
      if (wr) begin
        j  = youngest(addr);
        co = 1'b0;
`ifdef STB_COALESCE_EN
        co = (j >= 0) && !(dr && j == 0);
        if (co) begin
          t = mq[j];
          t.d = wd;
          mq[j] = t;
        end
`endif
        if (!co) begin
          if (mq.size() == DEPTH) e.stall = 1'b1;
          else mq.push_back('{a: addr, d: wd});
        end
      end
      if (dr) begin
        t = mq.pop_front();
        mdl_mem[t.a[7:2]] = t.d;
        mdl_val[t.a[7:2]] = 1'b1;
      end
    end
    cyc_q.push_back(e);
    last_stall = e.stall;
  endtask

  // Monitor
  exp_cyc_t m_ec;
  ent_t     m_ent;
  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      m_ec = cyc_q.pop_front();
      chk("MemRead",  32'(bus.MemRead),  32'(m_ec.rd));
      chk("MemWrite", 32'(bus.MemWrite), 32'(m_ec.wr));
      chk("stall",    32'(bus.stall),    32'(m_ec.stall));
      chk("count",    32'(count),        32'(m_ec.count));
      chk("empty",    32'(empty),        32'(m_ec.empty));
      if (m_ec.in_rst) begin
        chk("reset data_address", bus.data_address, 32'd0);
        chk("reset write_data",   bus.write_data,   32'd0);
        chk("reset core_rdata",   bus.core_rdata,   32'd0);
      end
      if (bus.MemWrite) begin
        if (wr_q.size() == 0) chk("pending drain count", 32'(wr_q.size()), 32'd1);
        else begin
          m_ent = wr_q.pop_front();
          chk("drain data_address", bus.data_address, m_ent.a);
          chk("drain write_data",   bus.write_data,   m_ent.d);
        end
      end
      if (bus.MemRead) begin
        if (ld_q.size() == 0) chk("pending load count", 32'(ld_q.size()), 32'd1);
        else begin
          m_ent = ld_q.pop_front();
          chk("load data_address", bus.data_address, m_ent.a);
          chk("load core_rdata",   bus.core_rdata,   m_ent.d);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, %0d vectors, %0d miscompares", n_vec, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned k;
    logic [31:0] ra;
    logic [31:0] rd_;
    logic [31:0] held_a;
    logic [31:0] held_d;
    held_a = '0;
    held_d = '0;
    rst               = 1'b1;
    bus.core_MemRead  = 1'b0;
    bus.core_MemWrite = 1'b0;
    bus.core_addr     = '0;
    bus.core_wdata    = '0;

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    // single store drains next cycle, buffer then empty
    cyc(0, 0, 1, 32'h0, 32'h4);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // store then forwarding load, drain follows
    cyc(0, 0, 1, 32'h8, 32'hAA);
    cyc(0, 1, 0, 32'h8, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // stores interleaved with loads to 0x40, then a further store
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 32'(4 * i), 32'h100 + 32'(i));
      cyc(0, 1, 0, 32'h40, 0);
    end
    cyc(0, 0, 1, 32'h10, 32'h55);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // two stores to one address, then load it
    cyc(0, 0, 1, 32'h10, 32'h1);
    cyc(0, 0, 1, 32'h10, 32'h2);
    cyc(0, 1, 0, 32'h10, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // reset discards buffered stores
    cyc(0, 0, 1, 32'h24, 32'h11);
    cyc(0, 1, 0, 32'h40, 0);
    cyc(0, 0, 1, 32'h28, 32'h22);
    cyc(0, 1, 0, 32'h40, 0);
    cyc(0, 0, 1, 32'h2C, 32'h33);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 32'h2C, 0);
    cyc(0, 1, 0, 32'h28, 0);
    cyc(0, 0, 0, 0, 0);
    // load and store together: store dropped
    cyc(0, 1, 1, 32'h14, 32'h77);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 32'h14, 0);

    for (int n = 0; n < 1500; n++) begin
      ra  = (32'($urandom_range(0, 7)) << 2) |
            (($urandom_range(0, 9) == 0) ? 32'h8000_0000 : 32'h0);
      rd_ = $urandom;
      k   = $urandom_range(0, 99);
      if (last_stall) cyc(0, 0, 1, held_a, held_d);
      else if (k < 1)  cyc(1, 0, 0, ra, rd_);
      else if (k < 41) cyc(0, 1, 0, ra, rd_);
      else if (k < 81) begin
        held_a = ra;
        held_d = rd_;
        cyc(0, 0, 1, ra, rd_);
      end
      else if (k < 86) cyc(0, 1, 1, ra, rd_);
      else             cyc(0, 0, 0, ra, rd_);
    end

    repeat (4) cyc(0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("outstanding expectations", 32'(cyc_q.size() + wr_q.size() + ld_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
